// File: rtl/foreign_pfx_decoder.sv
// x86 prefix/escape/opcode/ModRM/SIB pre-decoder. A two-register pipeline: a scan stage
// captures the window decode, and a classify stage registers the results plus a subreg table bit.
module foreign_pfx_decoder #(
  parameter int unsigned WIN_BYTES = 8,
  parameter int unsigned TBL_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is64,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*WIN_BYTES-1:0] in_bytes,
  input  logic                   flush,
  input  logic                   tbl_we,
  input  logic [3:0]             tbl_waddr,
  input  logic [63:0]            tbl_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_opcode,
  output logic [1:0]             out_map,
  output logic [1:0]             out_rep,
  output logic                   out_lock,
  output logic                   out_asz,
  output logic [4:0]             out_rex,
  output logic [3:0]             out_len,
  output logic [7:0]             out_modrm,
  output logic [7:0]             out_sib,
  output logic [5:0]             out_flags,
  output logic                   out_err
);

  typedef enum logic [1:0] {
    PH_PFX,
    PH_ESC,
    PH_OPC
  } scan_ph_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic [1:0] map;
    logic [1:0] rep;
    logic       lock;
    logic       asz;
    logic [4:0] rex;
    logic [3:0] len;
    logic [7:0] modrm;
    logic [7:0] sib;
    logic       modrm_in;
    logic       sib_in;
    logic       err;
  } s1_t;

  s1_t         s1_d, s1_q;
  logic        s1_v_d, s1_v_q;
  logic        s2_v_d, s2_v_q;
  logic        s2_load, accept, adv;
  scan_ph_e    ph;
  logic        found;
  logic [7:0]  b;
  logic [63:0] tbl_q [TBL_WORDS];
  logic [9:0]  tidx;
  logic [63:0] trow;
  logic        subreg, has_sib, rip_rel, no_base, no_index, trunc;
  logic [5:0]  flags_d;

  // Scan: once the opcode is found, later bytes are ignored; a missing opcode zeroes everything.
  always_comb begin
    s1_d  = '0;
    ph    = PH_PFX;
    found = 1'b0;
    b     = '0;
    for (int unsigned k = 0; k < WIN_BYTES; k++) begin
      b = in_bytes[8*k +: 8];
      if (!found) begin
        case (ph)
          PH_PFX: begin
            case (b)
              8'h66: begin s1_d.rep = 2'd1; s1_d.rex = '0; end
              8'hF2: begin s1_d.rep = 2'd2; s1_d.rex = '0; end
              8'hF3: begin s1_d.rep = 2'd3; s1_d.rex = '0; end
              8'hF0: begin s1_d.lock = 1'b1; s1_d.rex = '0; end
              8'h67: begin s1_d.asz = 1'b1; s1_d.rex = '0; end
              8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65: s1_d.rex = '0;
              8'h0F: begin s1_d.map = 2'd1; ph = PH_ESC; end
              default: begin
                if (is64 && (b[7:4] == 4'h4)) begin
                  s1_d.rex = {1'b1, b[3:0]};
                end else begin
                  s1_d.opcode = b;
                  s1_d.len    = 4'(k + 1);
                  found       = 1'b1;
                end
              end
            endcase
          end
          PH_ESC: begin
            if (b == 8'h38) begin
              s1_d.map = 2'd2;
              ph       = PH_OPC;
            end else if (b == 8'h3A) begin
              s1_d.map = 2'd3;
              ph       = PH_OPC;
            end else begin
              s1_d.opcode = b;
              s1_d.len    = 4'(k + 1);
              found       = 1'b1;
            end
          end
          default: begin
            s1_d.opcode = b;
            s1_d.len    = 4'(k + 1);
            found       = 1'b1;
          end
        endcase
      end
    end
    for (int unsigned k = 0; k < WIN_BYTES; k++) begin
      if (found && (k == 32'(s1_d.len)))       s1_d.modrm = in_bytes[8*k +: 8];
      if (found && (k == 32'(s1_d.len) + 1))   s1_d.sib   = in_bytes[8*k +: 8];
    end
    s1_d.modrm_in = found && (32'(s1_d.len) < WIN_BYTES);
    s1_d.sib_in   = found && (32'(s1_d.len) + 1 < WIN_BYTES);
    if (!found) begin
      s1_d     = '0;
      s1_d.err = 1'b1;
    end
  end

  always_comb begin
    tidx     = {s1_q.map, s1_q.opcode};
    trow     = tbl_q[tidx[9:6]];
    subreg   = trow[tidx[5:0]];
    has_sib  = (s1_q.modrm[7:6] != 2'b11) && (s1_q.modrm[2:0] == 3'b100);
    rip_rel  = (s1_q.modrm[7:6] == 2'b00) && (s1_q.modrm[2:0] == 3'b101);
    no_base  = has_sib && (s1_q.modrm[7:6] == 2'b00) && (s1_q.sib[2:0] == 3'b101);
    no_index = has_sib && (s1_q.sib[5:3] == 3'b100) && !s1_q.rex[1];
    trunc    = !s1_q.modrm_in || (has_sib && !s1_q.sib_in);
    flags_d  = s1_q.err ? '0 : {subreg, has_sib, rip_rel, no_base, no_index, trunc};
  end

  assign s2_load   = !s2_v_q || out_ready;
  assign in_ready  = !s1_v_q || s2_load;
  assign accept    = in_valid && in_ready && !flush;
  assign adv       = s1_v_q && s2_load && !flush;
  assign out_valid = s2_v_q;

  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else begin
      if (s2_load) s2_v_d = s1_v_q;
      if (accept)       s1_v_d = 1'b1;
      else if (s2_load) s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s1_q       <= '0;
      out_opcode <= '0;
      out_map    <= '0;
      out_rep    <= '0;
      out_lock   <= 1'b0;
      out_asz    <= 1'b0;
      out_rex    <= '0;
      out_len    <= '0;
      out_modrm  <= '0;
      out_sib    <= '0;
      out_flags  <= '0;
      out_err    <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (accept) s1_q <= s1_d;
      if (adv) begin
        out_opcode <= s1_q.opcode;
        out_map    <= s1_q.map;
        out_rep    <= s1_q.rep;
        out_lock   <= s1_q.lock;
        out_asz    <= s1_q.asz;
        out_rex    <= s1_q.rex;
        out_len    <= s1_q.len;
        out_modrm  <= s1_q.modrm;
        out_sib    <= s1_q.sib;
        out_flags  <= flags_d;
        out_err    <= s1_q.err;
      end
    end
  end

  // The lookup reads tbl_q before this edge's write lands, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned w = 0; w < TBL_WORDS; w++) tbl_q[w] <= '0;
    end else if (tbl_we) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

endmodule

// File: tb/tb_foreign_pfx_decoder.sv
// Self-checking bench for foreign_pfx_decoder: directed test-plan vectors plus randomized
// traffic scored against a transaction-level reference decoder.
module tb_foreign_pfx_decoder;

  localparam int unsigned WB = 8;

  logic        clk = 1'b0;
  logic        rst, is64, in_valid, in_ready, flush, tbl_we;
  logic [63:0] in_bytes, tbl_wdata;
  logic [3:0]  tbl_waddr;
  logic        out_valid, out_ready, out_lock, out_asz, out_err;
  logic [7:0]  out_opcode, out_modrm, out_sib;
  logic [1:0]  out_map, out_rep;
  logic [4:0]  out_rex;
  logic [3:0]  out_len;
  logic [5:0]  out_flags;

  int          passed = 0;
  int          total  = 0;
  int unsigned cyc    = 0;
  logic [45:0] exp_q [$];
  int unsigned cyc_q [$];
  logic [63:0] tbl_m [16];
  logic        nxt_we = 1'b0;
  logic [3:0]  nxt_wa = '0;
  logic [63:0] nxt_wd = '0;

  foreign_pfx_decoder #(.WIN_BYTES(WB), .TBL_WORDS(16)) dut (
    .clk(clk), .rst(rst), .is64(is64), .in_valid(in_valid), .in_ready(in_ready),
    .in_bytes(in_bytes), .flush(flush), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
    .tbl_wdata(tbl_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_map(out_map), .out_rep(out_rep), .out_lock(out_lock),
    .out_asz(out_asz), .out_rex(out_rex), .out_len(out_len), .out_modrm(out_modrm),
    .out_sib(out_sib), .out_flags(out_flags), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [45:0] pk(input logic [7:0] opc, input logic [1:0] map,
                                     input logic [1:0] rep, input logic lock, input logic asz,
                                     input logic [4:0] rex, input logic [3:0] len,
                                     input logic [7:0] modrm, input logic [7:0] sib,
                                     input logic [5:0] flags, input logic err);
    return {opc, map, rep, lock, asz, rex, len, modrm, sib, flags, err};
  endfunction

  function automatic logic [45:0] dut_out();
    return pk(out_opcode, out_map, out_rep, out_lock, out_asz, out_rex, out_len,
              out_modrm, out_sib, out_flags, out_err);
  endfunction

  function automatic logic is_rex(input logic [7:0] b, input logic m64);
    return m64 && (b >= 8'h40) && (b <= 8'h4F);
  endfunction

  function automatic logic is_pfx(input logic [7:0] b, input logic m64);
    case (b)
      8'h66, 8'hF2, 8'hF3, 8'hF0, 8'h67, 8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65: return 1'b1;
      default: return is_rex(b, m64);
    endcase
  endfunction

  // Reference: skip the prefix run, then resolve escape and opcode, then classify.
  function automatic logic [45:0] ref_decode(input logic [63:0] w, input logic m64);
    logic [7:0]  bt [16];
    int unsigned n, at, idx;
    logic [1:0]  map, rep;
    logic        lock, asz, hs, rip, nb, ni, tr, sr;
    logic [4:0]  rex;
    logic [7:0]  opc, modrm, sib;
    for (int i = 0; i < 16; i++) bt[i] = 8'h00;
    for (int i = 0; i < WB; i++) bt[i] = w[8*i +: 8];
    n = 0;
    while (n < WB && is_pfx(bt[n], m64)) n++;
    rep = 0; lock = 0; asz = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (bt[i] == 8'h66) rep = 2'd1;
      if (bt[i] == 8'hF2) rep = 2'd2;
      if (bt[i] == 8'hF3) rep = 2'd3;
      if (bt[i] == 8'hF0) lock = 1'b1;
      if (bt[i] == 8'h67) asz = 1'b1;
    end
    rex = (n > 0 && is_rex(bt[n-1], m64)) ? {1'b1, bt[n-1][3:0]} : 5'd0;
    map = 0;
    at  = n;
    if (n < WB && bt[n] == 8'h0F) begin
      map = 2'd1;
      at  = n + 1;
      if (at < WB && bt[at] == 8'h38) begin map = 2'd2; at++; end
      else if (at < WB && bt[at] == 8'h3A) begin map = 2'd3; at++; end
    end
    if (at >= WB) return pk('0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b1);
    opc   = bt[at];
    modrm = bt[at+1];
    sib   = bt[at+2];
    idx   = 256 * map + opc;
    sr    = tbl_m[idx / 64][idx % 64];
    hs    = (modrm[7:6] != 2'b11) && (modrm[2:0] == 3'd4);
    rip   = (modrm[7:6] == 2'b00) && (modrm[2:0] == 3'd5);
    nb    = hs && (modrm[7:6] == 2'b00) && (sib[2:0] == 3'd5);
    ni    = hs && (sib[5:3] == 3'd4) && !rex[1];
    tr    = (at + 1 >= WB) || (hs && at + 2 >= WB);
    return pk(opc, map, rep, lock, asz, rex, 4'(at + 1), modrm, sib,
              {sr, hs, rip, nb, ni, tr}, 1'b0);
  endfunction

  function automatic logic [7:0] rb();
    case ($urandom_range(0, 9))
      0: return 8'h66;
      1: return ($urandom_range(0, 1) != 0) ? 8'hF2 : 8'hF3;
      2: return ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'h67;
      3: return ($urandom_range(0, 1) != 0) ? 8'h2E : 8'h64;
      4: return 8'(8'h40 + $urandom_range(0, 15));
      5: return 8'h0F;
      6: return ($urandom_range(0, 1) != 0) ? 8'h38 : 8'h3A;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [63:0] rand_win();
    logic [63:0] w;
    for (int i = 0; i < WB; i++) w[8*i +: 8] = rb();
    return w;
  endfunction

  // One clock: drive at negedge, check against the scoreboard, advance the model.
  task automatic cycle(input logic iv, input logic [63:0] w, input logic m64, input logic ordy,
                       input logic fl, input logic ovr, input logic [45:0] oexp);
    logic        e_rdy, e_vld;
    logic [45:0] act;
    @(negedge clk);
    in_valid  = iv;
    in_bytes  = w;
    is64      = m64;
    out_ready = ordy;
    flush     = fl;
    tbl_we    = nxt_we;
    tbl_waddr = nxt_wa;
    tbl_wdata = nxt_wd;
    #1;
    e_rdy = (exp_q.size() < 2) || ordy;
    e_vld = (exp_q.size() > 0) && (cyc >= cyc_q[0] + 2);
    total++;
    if (in_ready !== e_rdy) $display("FAIL in_ready cyc=%0d: got %b expected %b", cyc, in_ready, e_rdy);
    else passed++;
    total++;
    if (out_valid !== e_vld) $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, out_valid, e_vld);
    else passed++;
    if (e_vld) begin
      act = dut_out();
      total++;
      if (act !== exp_q[0]) $display("FAIL out_data cyc=%0d: got %h expected %h", cyc, act, exp_q[0]);
      else passed++;
    end
    if (nxt_we) tbl_m[nxt_wa] = nxt_wd;
    nxt_we = 1'b0;
    if (fl) begin
      exp_q.delete();
      cyc_q.delete();
    end else begin
      if (e_vld && ordy) begin
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
      if (iv && e_rdy) begin
        exp_q.push_back(ovr ? oexp : ref_decode(w, m64));
        cyc_q.push_back(cyc);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic present(input logic [63:0] w, input logic m64, input logic [45:0] e);
    cycle(1'b1, w, m64, 1'b1, 1'b0, 1'b1, e);
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_bytes = '0; is64 = 1; flush = 0; out_ready = 1;
    tbl_we = 0; tbl_waddr = '0; tbl_wdata = '0;
    for (int i = 0; i < 16; i++) tbl_m[i] = '0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || dut_out() !== '0) $display("FAIL reset_out: got v=%b d=%h expected 0", out_valid, dut_out());
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready);
    else passed++;
  endtask

  task automatic test_basic();
    present(64'h000000C3_AF0F4866, 1'b1, pk(8'hAF, 1, 1, 0, 0, 5'b11000, 4, 8'hC3, 8'h00, 6'b000000, 0));
    present(64'h00000025_0400380F, 1'b1, pk(8'h00, 2, 0, 0, 0, 5'b00000, 3, 8'h04, 8'h25, 6'b010110, 0));
  endtask

  task automatic test_mode_rex();
    present(64'h00000000_00009048, 1'b0, pk(8'h48, 0, 0, 0, 0, 5'b00000, 1, 8'h90, 8'h00, 6'b000000, 0));
    present(64'h00000000_C0896648, 1'b1, pk(8'h89, 0, 1, 0, 0, 5'b00000, 3, 8'hC0, 8'h00, 6'b000000, 0));
  endtask

  task automatic test_err_trunc();
    present(64'h66666666_66666666, 1'b1, pk(8'h00, 0, 0, 0, 0, 5'b00000, 0, 8'h00, 8'h00, 6'b000000, 1));
    present(64'h8B0F6666_66666666, 1'b1, pk(8'h8B, 1, 1, 0, 0, 5'b00000, 8, 8'h00, 8'h00, 6'b000001, 0));
  endtask

  task automatic test_table();
    cycle(1'b1, 64'h00000000_00C0000F, 1'b1, 1'b1, 1'b0, 1'b1,
          pk(8'h00, 1, 0, 0, 0, 5'b00000, 2, 8'hC0, 8'h00, 6'b000000, 0));
    nxt_we = 1'b1; nxt_wa = 4'd4; nxt_wd = 64'h1;
    idle(2);
    present(64'h00000000_00C0000F, 1'b1, pk(8'h00, 1, 0, 0, 0, 5'b00000, 2, 8'hC0, 8'h00, 6'b100000, 0));
  endtask

  task automatic test_handshake_flush();
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_win(), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, rand_win(), 1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_win(), $urandom_range(0, 1) != 0, 1'b1, 1'b0, 1'b0, '0);
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      nxt_we = 1'b1; nxt_wa = 4'(i); nxt_wd = {$urandom, $urandom};
      idle(1);
    end
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, rand_win(), $urandom_range(0, 1) != 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, 1'b0, '0);
    idle(3);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, rand_win(), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, rand_win(), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_out() !== '0)
      $display("FAIL mid_reset: got v=%b r=%b d=%h expected v=0 r=1 d=0", out_valid, in_ready, dut_out());
    else passed++;
    exp_q.delete();
    cyc_q.delete();
    for (int i = 0; i < 16; i++) tbl_m[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    present(64'h000000C3_AF0F4866, 1'b1, pk(8'hAF, 1, 1, 0, 0, 5'b11000, 4, 8'hC3, 8'h00, 6'b000000, 0));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode_rex();
    test_err_trunc();
    test_table();
    test_handshake_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
